// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU IO-space bridge to per-channel peripherals with ack timeout
// Decodes the top 1 KiB window, latches one access and stalls the CPU until ack, timeout or unmapped error.
module mmio_bridge #(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 4,
  parameter int CH_SHIFT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_rd,
  input  logic                         cpu_wr,
  input  logic [31:0]                  cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         cpu_err,
  output logic [CHANNELS-1:0]          io_sel,
  output logic                         io_rd,
  output logic                         io_wr,
  output logic [CH_SHIFT-1:0]          io_addr,
  output logic [DATA_W-1:0]            io_wdata,
  input  logic [CHANNELS*DATA_W-1:0]   io_rdata,
  input  logic [CHANNELS-1:0]          io_ack
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                err_q, err_d;
  logic                op_wr_q, op_wr_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic [CH_SHIFT-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                io_req;
  logic [CH_W-1:0]     ch_idx;
  logic                ch_mapped;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdata;
  logic                unused_addr;

  assign unused_addr = ^cpu_addr;

  always_comb begin
    io_req    = (cpu_addr[31:10] == 22'h3FFFFF) && (cpu_rd || cpu_wr);
    ch_idx    = cpu_addr[CH_SHIFT +: CH_W];
    ch_mapped = (int'(ch_idx) < CHANNELS);
    sel_ack   = 1'b0;
    sel_rdata = '0;
    io_sel    = '0;
    // Only the latched channel's ack and data are ever looked at.
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx_q == CH_W'(k)) begin
        sel_ack   = io_ack[k];
        sel_rdata = io_rdata[k*DATA_W +: DATA_W];
      end
      io_sel[k] = (state_q == S_ACCESS) && (idx_q == CH_W'(k));
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    err_d       = err_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (io_req) begin
          if (ch_mapped) begin
            state_d    = S_ACCESS;
            op_wr_d    = cpu_wr;
            idx_d      = ch_idx;
            io_addr_d  = cpu_addr[CH_SHIFT-1:0];
            io_wdata_d = cpu_wdata;
            cnt_d      = '0;
            err_d      = 1'b0;
          end else begin
            state_d     = S_DONE;
            err_d       = 1'b1;
            cpu_rdata_d = '1;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the timeout cycle still completes normally.
        if (sel_ack) begin
          if (!op_wr_q) cpu_rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          if (!op_wr_q) cpu_rdata_d = '1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cpu_rdata_q <= '0;
      err_q       <= 1'b0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_q       <= err_d;
      op_wr_q     <= op_wr_d;
      idx_q       <= idx_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Stall is gated by reset so a held request cannot freeze the CPU while in reset.
  assign cpu_stall = rst_n && (((state_q == S_IDLE) && io_req) || (state_q == S_ACCESS));
  assign cpu_err   = (state_q == S_DONE) && err_q;
  assign io_rd     = (state_q == S_ACCESS) && !op_wr_q;
  assign io_wr     = (state_q == S_ACCESS) && op_wr_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - scoreboard bench for mmio_bridge with 3 channels and an 8-cycle timeout
module tb_mmio_bridge;
  localparam int TIMEOUT = 8;
  localparam int NCH     = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_rd, cpu_wr;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall, cpu_err;
  logic [NCH-1:0] io_sel;
  logic          io_rd, io_wr;
  logic [3:0]    io_addr;
  logic [31:0]   io_wdata;
  logic [NCH*32-1:0] io_rdata;
  logic [NCH-1:0] io_ack;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rdata = 32'h0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_bridge #(.DATA_W(32), .CHANNELS(NCH), .CH_SHIFT(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .io_sel(io_sel), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  task automatic test_reset();
    rst_n = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'hFFFFFC24; cpu_wdata = 32'h0;
    io_rdata = '0; io_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", cpu_err); end
    n_checks++; if ({io_sel, io_rd, io_wr} !== 5'b0) begin n_fail++; $display("FAIL reset_io: got %b expected 0", {io_sel, io_rd, io_wr}); end
    n_checks++; if ({io_addr, io_wdata} !== 36'h0) begin n_fail++; $display("FAIL reset_io_data: got %h expected 0", {io_addr, io_wdata}); end
    cpu_rd = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({cpu_stall, cpu_err, io_sel} !== 5'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", {cpu_stall, cpu_err, io_sel}); end
  endtask

  // ack_at: ACCESS cycle (1-based) on which the selected channel acks; 0 means never.
  task automatic run_txn(input string name, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at, input logic [31:0] ack_data);
    logic mapped;
    logic [NCH-1:0] exp_sel;
    int exp_stall, stalls, acc;
    logic [32:0] exp, got_exp;
    mapped  = (addr[5:4] < 2'd3);
    exp_sel = mapped ? (3'b001 << addr[5:4]) : 3'b000;
    if (!mapped) begin
      exp_stall = 1; exp = {1'b1, 32'hFFFFFFFF};
    end else if (ack_at > 0) begin
      exp_stall = ack_at + 1; exp = {1'b0, wr ? model_rdata : ack_data};
    end else begin
      exp_stall = TIMEOUT + 1; exp = {1'b1, wr ? model_rdata : 32'hFFFFFFFF};
    end
    model_rdata = exp[31:0];
    exp_q.push_back(exp);
    for (int k = 0; k < NCH; k++) io_rdata[k*32 +: 32] = exp_sel[k] ? ack_data : (32'hBAD00000 | k);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    stalls = 0; acc = 0;
    #1;
    for (int c = 0; c < 40 && cpu_stall; c++) begin
      stalls++;
      n_checks++;
      if ((io_rd && io_wr) || !$onehot0(io_sel)) begin
        n_fail++; $display("FAIL %s io_exclusive: got sel=%b rd=%b wr=%b expected at most one", name, io_sel, io_rd, io_wr);
      end
      if (io_sel != '0) begin
        acc++;
        if (acc == 1) begin
          n_checks++; if (io_sel !== exp_sel) begin n_fail++; $display("FAIL %s io_sel: got %b expected %b", name, io_sel, exp_sel); end
          n_checks++; if ({io_rd, io_wr} !== {!wr, wr}) begin n_fail++; $display("FAIL %s io_op: got rd=%b wr=%b expected rd=%b wr=%b", name, io_rd, io_wr, !wr, wr); end
          n_checks++; if ({io_addr, io_wdata} !== {addr[3:0], wdata}) begin n_fail++; $display("FAIL %s io_addr_wdata: got %h/%h expected %h/%h", name, io_addr, io_wdata, addr[3:0], wdata); end
        end
        io_ack = (acc == ack_at) ? 3'b111 : ~exp_sel;
      end
      @(posedge clk);
      #1;
    end
    io_ack = '0;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_bound: got stall stuck expected release within 40 cycles", name); end
    n_checks++; if (stalls != exp_stall) begin n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall); end
    if (!mapped) begin
      n_checks++; if (acc != 0) begin n_fail++; $display("FAIL %s unmapped_sel: got %0d access cycles expected 0", name, acc); end
    end
    got_exp = exp_q.pop_front();
    n_checks++; if (cpu_rdata !== got_exp[31:0]) begin n_fail++; $display("FAIL %s rdata: got %h expected %h", name, cpu_rdata, got_exp[31:0]); end
    n_checks++; if (cpu_err !== got_exp[32]) begin n_fail++; $display("FAIL %s err: got %b expected %b", name, cpu_err, got_exp[32]); end
    n_checks++; if ({io_sel, io_rd, io_wr} !== 5'b0) begin n_fail++; $display("FAIL %s done_io: got %b expected 0", name, {io_sel, io_rd, io_wr}); end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if ({cpu_err, cpu_stall} !== 2'b00) begin n_fail++; $display("FAIL %s err_pulse: got err=%b stall=%b expected 0 0", name, cpu_err, cpu_stall); end
  endtask

  task automatic test_read_write();
    run_txn("read_ch2", 1'b1, 1'b0, 32'hFFFFFC24, 32'h0, 3, 32'h00ABCDEF);
    run_txn("write_ch0", 1'b0, 1'b1, 32'hFFFFFC00, 32'h5A, 1, 32'h12345678);
    run_txn("read_ch1", 1'b1, 1'b0, 32'hFFFFFC1C, 32'h0, 2, 32'h13579BDF);
  endtask

  task automatic test_errors();
    run_txn("unmapped", 1'b1, 1'b0, 32'hFFFFFC30, 32'h0, 0, 32'h0);
    run_txn("read_ch0", 1'b1, 1'b0, 32'hFFFFFC08, 32'h0, 1, 32'h2468ACE0);
    run_txn("wr_timeout", 1'b0, 1'b1, 32'hFFFFFC24, 32'h77, 0, 32'h0);
    run_txn("rd_timeout", 1'b1, 1'b0, 32'hFFFFFC14, 32'h0, 0, 32'h0);
  endtask

  task automatic test_corners();
    run_txn("rd_wr_both", 1'b1, 1'b1, 32'hFFFFFC18, 32'hCAFE, 1, 32'h11112222);
    run_txn("ack_at_timeout", 1'b1, 1'b0, 32'hFFFFFC04, 32'h0, TIMEOUT, 32'h0BADF00D);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h00000010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({cpu_stall, io_sel, io_rd, io_wr, cpu_err} !== 7'b0) begin
        n_fail++; $display("FAIL non_io: got %b expected 0", {cpu_stall, io_sel, io_rd, io_wr, cpu_err});
      end
      @(posedge clk);
    end
    #1;
    cpu_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'b1, 1'b0, 32'hFFFFFC2C, 32'h0, 1, 32'hA5A5A5A5);
    run_txn("b2b_second", 1'b0, 1'b1, 32'hFFFFFC10, 32'h3C3C, 2, 32'h0);
  endtask

  task automatic test_reset_mid_access();
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'hFFFFFC28;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (io_sel !== 3'b100) begin n_fail++; $display("FAIL mid_reset_setup: got sel %b expected 100", io_sel); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({io_sel, io_rd, cpu_stall} !== 5'b0) begin n_fail++; $display("FAIL mid_reset_drop: got %b expected 0", {io_sel, io_rd, cpu_stall}); end
    cpu_rd = 1'b0;
    model_rdata = 32'h0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({cpu_err, cpu_stall, io_sel} !== 5'b0 || cpu_rdata !== model_rdata) begin
        n_fail++; $display("FAIL mid_reset_after: got err=%b stall=%b sel=%b rdata=%h expected 0 0 000 %h", cpu_err, cpu_stall, io_sel, cpu_rdata, model_rdata);
      end
    end
    run_txn("after_reset_rd", 1'b1, 1'b0, 32'hFFFFFC20, 32'h0, 1, 32'hFEEDBEEF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_write();
    test_errors();
    test_corners();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
